// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: pong match sequencer (serve/play/point pause/game over), per-frame ball gating, score keeping
module pong_match_ctrl #(
  parameter int WIN_SCORE    = 11,
  parameter int PAUSE_FRAMES = 60,
  parameter int SLOW_DIV     = 60,
  parameter int SCORE_W      = 7
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               serve_btn,
  input  logic               slow,
  input  logic               scored,
  input  logic               point_side,
  output logic               ball_en,
  output logic               ball_hold,
  output logic               serve_dir,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic               game_over,
  output logic               winner
);
  localparam int PW = $clog2(PAUSE_FRAMES + 1);
  localparam int DW = $clog2(SLOW_DIV + 1);
  typedef enum logic [1:0] {SERVE_WAIT, PLAY, POINT_PAUSE, GAME_OVER} state_t;
  state_t state, state_n;
  logic btn_q, serve_rise, win, in_play, div_last;
  logic [SCORE_W-1:0] pts;
  logic [PW-1:0] pause_cnt;
  logic [DW-1:0] div_cnt;
  assign serve_rise = serve_btn & ~btn_q;
  assign in_play    = state == PLAY;
  assign pts        = point_side ? right_score : left_score;
  assign win        = pts + SCORE_W'(1) == SCORE_W'(WIN_SCORE);
  assign div_last   = div_cnt == DW'(SLOW_DIV - 1);
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= SERVE_WAIT;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      SERVE_WAIT:  state_n = serve_rise ? PLAY : state;
      PLAY:        state_n = scored ? (win ? GAME_OVER : POINT_PAUSE) : state;
      POINT_PAUSE: state_n = (frame_tick && pause_cnt == '0) ? SERVE_WAIT : state;
      GAME_OVER:   state_n = serve_rise ? SERVE_WAIT : state;
    endcase
  end
  always_comb begin
    ball_hold = ~in_play;
    game_over = state == GAME_OVER;
    ball_en   = in_play & frame_tick & (~slow | div_last);
  end
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      btn_q       <= 1'b1;
      left_score  <= '0;
      right_score <= '0;
      serve_dir   <= 1'b0;
      winner      <= 1'b0;
      div_cnt     <= '0;
      pause_cnt   <= '0;
    end else begin
      btn_q   <= serve_btn;
      div_cnt <= (in_play && slow) ? (frame_tick ? (div_last ? '0 : div_cnt + DW'(1)) : div_cnt) : '0;
      if (in_play && scored) begin
        serve_dir <= point_side;
        if (point_side) right_score <= right_score + SCORE_W'(1);
        else left_score <= left_score + SCORE_W'(1);
        if (win) winner <= point_side;
        else pause_cnt <= PW'(PAUSE_FRAMES - 1);
      end else if (state == POINT_PAUSE && frame_tick && pause_cnt != '0) begin
        pause_cnt <= pause_cnt - PW'(1);
      end else if (state == GAME_OVER && serve_rise) begin
        left_score  <= '0;
        right_score <= '0;
        serve_dir   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed self-checking bench for pong_match_ctrl
module tb_pong_match_ctrl;
  logic clk = 0, reset = 1, frame_tick = 0, serve_btn = 1, slow = 0, scored = 0, point_side = 0;
  logic ball_en, ball_hold, serve_dir, game_over, winner;
  logic [6:0] left_score, right_score;
  int n_chk = 0, n_fail = 0;
  logic en;
  logic [8:0] ens;
  pong_match_ctrl #(.WIN_SCORE(3), .PAUSE_FRAMES(60), .SLOW_DIV(3), .SCORE_W(7)) dut (
    .CLOCK_50(clk), .reset(reset), .frame_tick(frame_tick), .serve_btn(serve_btn), .slow(slow),
    .scored(scored), .point_side(point_side), .ball_en(ball_en), .ball_hold(ball_hold),
    .serve_dir(serve_dir), .left_score(left_score), .right_score(right_score),
    .game_over(game_over), .winner(winner)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick(output logic e);
    frame_tick = 1;
    #1 e = ball_en;
    step();
    frame_tick = 0;
  endtask
  task automatic serve();
    serve_btn = 1;
    step();
    serve_btn = 0;
    step();
  endtask
  task automatic point(input logic side);
    scored = 1;
    point_side = side;
    step();
    scored = 0;
  endtask
  task automatic pause_out(input int n, output logic any_en);
    logic e;
    any_en = 0;
    for (int i = 0; i < n; i++) begin
      tick(e);
      any_en |= e;
    end
  endtask
  initial begin
    step();
    tick(en);
    step();
    reset = 0;
    for (int i = 0; i < 4; i++) tick(en);
    step();
    chk("held_btn_hold", ball_hold, 1);
    chk("held_btn_en", en, 0);
    chk("reset_left", left_score, 0);
    chk("reset_right", right_score, 0);
    chk("reset_game_over", game_over, 0);
    chk("reset_serve_dir", serve_dir, 0);
    serve_btn = 0;
    step();
    chk("still_wait", ball_hold, 1);
    serve();
    chk("play_hold", ball_hold, 0);
    ens = '0;
    for (int i = 0; i < 5; i++) begin
      tick(en);
      ens[i] = en;
      step();
    end
    chk("fast_en", ens[4:0], 5'b11111);
    chk("no_en_off_tick", ball_en, 0);
    slow = 1;
    ens = '0;
    for (int i = 0; i < 9; i++) begin
      tick(en);
      ens[i] = en;
      step();
    end
    chk("slow_en", ens, 9'b100100100);
    slow = 0;
    scored = 1;
    point_side = 1;
    frame_tick = 1;
    #1 chk("en_with_scored", ball_en, 1);
    step();
    scored = 0;
    frame_tick = 0;
    chk("right_pt", right_score, 1);
    chk("left_unch", left_score, 0);
    chk("serve_dir_r", serve_dir, 1);
    chk("pause_hold", ball_hold, 1);
    pause_out(10, en);
    serve();
    chk("serve_ign_pause", ball_hold, 1);
    pause_out(49, en);
    chk("pause_no_en", en, 0);
    serve();
    chk("pause_59", ball_hold, 1);
    tick(en);
    serve();
    chk("pause_60_serve", ball_hold, 0);
    for (int p = 1; p <= 3; p++) begin
      point(0);
      chk($sformatf("left_pt%0d", p), left_score, p);
      if (p < 3) begin
        pause_out(60, en);
        serve();
      end
    end
    chk("serve_dir_l", serve_dir, 0);
    chk("go", game_over, 1);
    chk("winner", winner, 0);
    chk("go_right", right_score, 1);
    chk("go_hold", ball_hold, 1);
    point(0);
    point(1);
    chk("go_frz_l", left_score, 3);
    chk("go_frz_r", right_score, 1);
    chk("go_stay", game_over, 1);
    serve();
    chk("newgame_l", left_score, 0);
    chk("newgame_r", right_score, 0);
    chk("newgame_go", game_over, 0);
    chk("newgame_hold", ball_hold, 1);
    serve();
    chk("newgame_play", ball_hold, 0);
    point(1);
    pause_out(60, en);
    serve();
    point(0);
    pause_out(60, en);
    serve();
    point(0);
    chk("pre_rst_l", left_score, 2);
    chk("pre_rst_r", right_score, 1);
    chk("pre_rst_go", game_over, 0);
    reset = 1;
    step();
    reset = 0;
    frame_tick = 1;
    #1 chk("rst_en", ball_en, 0);
    chk("rst_l", left_score, 0);
    chk("rst_r", right_score, 0);
    chk("rst_hold", ball_hold, 1);
    chk("rst_dir", serve_dir, 0);
    step();
    frame_tick = 0;
    serve();
    chk("rst_serve_play", ball_hold, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
